// File: rtl/dequant_perchannel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dequant_perchannel_pipe
// Brief    : Per-channel fixed-point dequantizer y = (q - zp[ch]) * scale[ch],
//            3-stage pipeline with global valid/ready stall.
// Revision : 1.0 - initial release
// ============================================================================
module dequant_perchannel_pipe #(
    parameter int N     = 16,
    parameter int SW    = 16,
    parameter int SFRAC = 12,
    parameter int OW    = 16,
    parameter int NCH   = 8,
    parameter int CHW   = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [SW-1:0]  cfg_scale,
    input  logic [N-1:0]   cfg_zp,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  out_data,
    output logic [CHW-1:0] out_ch,
    output logic           out_last,
    output logic           out_sat,
    output logic [15:0]    sat_cnt
);

    localparam int PW = N + 1 + SW;
    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
    localparam logic [SW-1:0]  SCALE_ONE = {{(SW-SFRAC-1){1'b0}}, 1'b1, {SFRAC{1'b0}}};
    localparam logic signed [PW:0] RND_C = {{(PW-SFRAC+1){1'b0}}, 1'b1, {(SFRAC-1){1'b0}}};
    localparam logic signed [PW:0] MAX_C = {{(PW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [PW:0] MIN_C = {{(PW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic w_en;
    logic w_accept;

    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;
    assign w_accept = in_valid & w_en;

    // Coefficient table; read combinationally at accept so a same-cycle write
    // only affects later samples.
    logic [SW-1:0] scale_tab_q [NCH];
    logic [N-1:0]  zp_tab_q    [NCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                scale_tab_q[i] <= SCALE_ONE;
                zp_tab_q[i]    <= '0;
            end
        end else if (cfg_we) begin
            scale_tab_q[cfg_ch] <= cfg_scale;
            zp_tab_q[cfg_ch]    <= cfg_zp;
        end
    end

    logic [CHW-1:0] ch_cnt_q;
    logic [CHW-1:0] ch_cnt_d;

    always_comb begin
        ch_cnt_d = ch_cnt_q;
        if (w_accept) begin
            ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt_q <= '0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
        end
    end

    // Stage 1: zero-point subtraction at N+1 bits so it cannot overflow
    logic [N-1:0]         w_zp_sel;
    logic signed [N:0]    d1_d;
    logic                 v1_q;
    logic signed [N:0]    d1_q;
    logic signed [SW-1:0] s1_q;
    logic [CHW-1:0]       ch1_q;

    assign w_zp_sel = mode ? zp_tab_q[ch_cnt_q] : '0;
    assign d1_d     = $signed({in_data[N-1], in_data}) - $signed({w_zp_sel[N-1], w_zp_sel});

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            s1_q  <= '0;
            ch1_q <= '0;
        end else if (w_en) begin
            v1_q  <= in_valid;
            d1_q  <= d1_d;
            s1_q  <= $signed(scale_tab_q[ch_cnt_q]);
            ch1_q <= ch_cnt_q;
        end
    end

    // Stage 2: full-precision signed product
    logic signed [PW-1:0] p2_d;
    logic                 v2_q;
    logic signed [PW-1:0] p2_q;
    logic [CHW-1:0]       ch2_q;

    assign p2_d = PW'(d1_q) * PW'(s1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q  <= 1'b0;
            p2_q  <= '0;
            ch2_q <= '0;
        end else if (w_en) begin
            v2_q  <= v1_q;
            p2_q  <= p2_d;
            ch2_q <= ch1_q;
        end
    end

    // Stage 3: round half up, then clamp to the output range
    logic signed [PW:0] w_biased;
    logic signed [PW:0] w_shift;
    logic [OW-1:0]      out_data_d;
    logic               out_sat_d;

    assign w_biased = $signed({p2_q[PW-1], p2_q}) + RND_C;
    assign w_shift  = w_biased >>> SFRAC;

    always_comb begin
        out_data_d = w_shift[OW-1:0];
        out_sat_d  = 1'b0;
        if (w_shift > MAX_C) begin
            out_data_d = {1'b0, {(OW-1){1'b1}}};
            out_sat_d  = 1'b1;
        end else if (w_shift < MIN_C) begin
            out_data_d = {1'b1, {(OW-1){1'b0}}};
            out_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (w_en) begin
            out_valid <= v2_q;
            out_data  <= out_data_d;
            out_ch    <= ch2_q;
            out_last  <= (ch2_q == LAST_CH);
            out_sat   <= out_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dequant_perchannel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dequant_perchannel_pipe
// Brief    : Directed self-checking bench for dequant_perchannel_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dequant_perchannel_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_scale;
    logic [15:0] cfg_zp;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_ch;
    logic        out_last;
    logic        out_sat;
    logic [15:0] sat_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dequant_perchannel_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_scale (cfg_scale),
        .cfg_zp    (cfg_zp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [15:0] sc, input logic [15:0] zp);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_scale = sc;
        cfg_zp    = zp;
        step();
        cfg_we = 1'b0;
    endtask

    // One isolated sample: checks accept, 3-cycle latency, result, then consumes it.
    task automatic send(input string tag, input logic [15:0] q, input logic m,
                        input int exp_d, input int exp_ch, input logic exp_sat);
        int lat;
        in_data  = q;
        mode     = m;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, $signed(out_data), exp_d);
        chk({tag, "_ch"}, 32'(out_ch), exp_ch);
        chk({tag, "_last"}, 32'(out_last), (exp_ch == 7) ? 1 : 0);
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        step();
        chk({tag, "_drained"}, 32'(out_valid), 0);
    endtask

    function automatic logic [15:0] stream_q(input int i);
        return 16'(i * 1237 - 12000);
    endfunction

    initial begin
        logic [3:0]  pat;
        int          sent;
        int          rcv;
        int          cyc;
        logic        held_v;
        logic [15:0] held_d;
        logic [2:0]  held_ch;

        rst = 1'b1; mode = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_scale = '0; cfg_zp = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_sat_cnt", 32'(sat_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        send("ch0_default", 16'd100, 1'b0, 100, 0, 1'b0);
        cfg(3'd1, 16'h0800, 16'd0);
        send("ch1_round_pos", 16'd3, 1'b0, 2, 1, 1'b0);
        cfg(3'd2, 16'h0800, 16'd0);
        send("ch2_round_neg", 16'hFFFD, 1'b0, -1, 2, 1'b0);
        cfg(3'd3, 16'h2000, 16'd10);
        send("ch3_asym", 16'd30, 1'b1, 40, 3, 1'b0);
        cfg(3'd4, 16'h2000, 16'd10);
        send("ch4_sym", 16'd30, 1'b0, 60, 4, 1'b0);
        cfg(3'd5, 16'h1000, 16'h8000);
        send("ch5_sat_hi", 16'd32767, 1'b1, 32767, 5, 1'b1);
        chk("sat_cnt_1", 32'(sat_cnt), 1);
        cfg(3'd6, 16'h1000, 16'd32767);
        send("ch6_sat_lo", 16'h8000, 1'b1, -32768, 6, 1'b1);
        chk("sat_cnt_2", 32'(sat_cnt), 2);
        send("ch7_last", 16'd7, 1'b0, 7, 7, 1'b0);

        // Table write racing an accept on the same channel
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_scale = 16'h2000; cfg_zp = 16'd0;
        send("hazard_old", 16'd5, 1'b0, 5, 0, 1'b0);
        send("fill_ch1", 16'd5, 1'b0, 3, 1, 1'b0);
        send("fill_ch2", 16'd5, 1'b0, 3, 2, 1'b0);
        send("fill_ch3", 16'd5, 1'b0, 10, 3, 1'b0);
        send("fill_ch4", 16'd5, 1'b0, 10, 4, 1'b0);
        send("fill_ch5", 16'd5, 1'b0, 5, 5, 1'b0);
        send("fill_ch6", 16'd5, 1'b0, 5, 6, 1'b0);
        send("fill_ch7", 16'd5, 1'b0, 5, 7, 1'b0);
        send("hazard_new", 16'd5, 1'b0, 10, 0, 1'b0);

        // Mid-stream reset with three samples in flight
        in_valid = 1'b1; in_data = 16'd5; mode = 1'b0;
        step();
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_out_data", 32'(out_data), 0);
        chk("mrst_sat_cnt", 32'(sat_cnt), 0);
        for (int i = 0; i < 6; i++) begin
            chk("mrst_no_output", 32'(out_valid), 0);
            step();
        end
        send("post_rst_ch0", 16'd5, 1'b0, 5, 0, 1'b0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // 20-sample stream under 1,0,0,1 backpressure
        pat = 4'b1001;
        sent = 0; rcv = 0; cyc = 0; held_v = 1'b0; held_d = '0; held_ch = '0;
        while (rcv < 20 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            if (sent < 20) begin
                in_valid = 1'b1;
                in_data  = stream_q(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                chk("stall_hold_data", 32'(out_data), 32'(held_d));
                chk("stall_hold_ch", 32'(out_ch), 32'(held_ch));
            end
            if (out_valid && out_ready) begin
                chk("stream_data", $signed(out_data), $signed(stream_q(rcv)));
                chk("stream_ch", 32'(out_ch), rcv % 8);
                chk("stream_last", 32'(out_last), (rcv % 8 == 7) ? 1 : 0);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            held_v  = out_valid && !out_ready;
            held_d  = out_data;
            held_ch = out_ch;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_received", rcv, 20);
        chk("stream_sent", sent, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
